// File: rtl/bitty_fetch_unit.sv
// ============================================================================
// Module   : bitty_fetch_unit
// Purpose  : Instruction fetch sequencer for the bitty core. It reads memory at
//            pc, latches the word, issues it with a run pulse and waits for done.
// Options  : BITTY_FETCH_WATCHDOG_EN builds the WAIT-state watchdog.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bitty_fetch_unit #(
  parameter int ADDR_W      = 8,
  parameter int LAST_ADDR   = 2**ADDR_W - 1,
  parameter int WDOG_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [15:0]       mem_rdata,
  output logic [15:0]       instr,
  output logic              run,
  input  logic              done,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              halted,
  output logic              wdog_err
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_LATCH = 3'd2;
  localparam logic [2:0] S_ISSUE = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;
  localparam logic [2:0] S_HALT  = 3'd5;

  localparam logic [ADDR_W-1:0] LAST_PC   = ADDR_W'(LAST_ADDR);
  localparam logic [15:0]       HALT_WORD = 16'hFFFF;

  logic [2:0]        r_state;
  logic [2:0]        w_next;
  logic [ADDR_W-1:0] r_pc;
  logic [15:0]       r_instr;
  logic              w_wdog_trip;
  logic              w_launch;

  // A start is only honoured when the unit is not busy.
  assign w_launch = start && ((r_state == S_IDLE) || (r_state == S_HALT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_REQ;
      S_REQ:   w_next = S_LATCH;
      S_LATCH: w_next = (mem_rdata == HALT_WORD) ? S_HALT : S_ISSUE;
      S_ISSUE: w_next = S_WAIT;
      S_WAIT: begin
        if (done) begin
          w_next = (r_pc == LAST_PC) ? S_HALT : S_REQ;
        end else if (w_wdog_trip) begin
          w_next = S_HALT;
        end
      end
      S_HALT:  if (start) w_next = S_REQ;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    mem_rd = 1'b0;
    run    = 1'b0;
    busy   = 1'b0;
    halted = 1'b0;
    case (r_state)
      S_REQ:   begin mem_rd = 1'b1; busy = 1'b1; end
      S_LATCH: busy = 1'b1;
      S_ISSUE: begin run = 1'b1; busy = 1'b1; end
      S_WAIT:  busy = 1'b1;
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc    <= '0;
      r_instr <= '0;
    end else begin
      if (w_launch) begin
        r_pc <= '0;
      end else if ((r_state == S_WAIT) && done && (r_pc != LAST_PC)) begin
        r_pc <= r_pc + ADDR_W'(1);
      end
      // The halt word is latched too, so instr shows what stopped the program.
      if (r_state == S_LATCH) begin
        r_instr <= mem_rdata;
      end
    end
  end

`ifdef BITTY_FETCH_WATCHDOG_EN
  localparam int                WDOG_W    = $clog2(WDOG_CYCLES + 1);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);

  logic [WDOG_W-1:0] r_wdog_cnt;
  logic              r_wdog_err;

  // Trips on the WDOG_CYCLES-th WAIT cycle without done; done wins a tie.
  assign w_wdog_trip = (r_state == S_WAIT) && !done && (r_wdog_cnt == WDOG_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wdog_cnt <= '0;
      r_wdog_err <= 1'b0;
    end else begin
      if (r_state == S_ISSUE) begin
        r_wdog_cnt <= '0;
      end else if ((r_state == S_WAIT) && !done) begin
        r_wdog_cnt <= r_wdog_cnt + WDOG_W'(1);
      end
      if (w_wdog_trip) begin
        r_wdog_err <= 1'b1;
      end else if ((r_state == S_HALT) && start) begin
        r_wdog_err <= 1'b0;
      end
    end
  end

  assign wdog_err = r_wdog_err;
`else
  assign w_wdog_trip = 1'b0;
  // No watchdog: the flag is a constant 0 (WDOG_CYCLES is never negative).
  assign wdog_err    = (WDOG_CYCLES < 0);
`endif

  assign mem_addr = r_pc;
  assign pc       = r_pc;
  assign instr    = r_instr;

endmodule

`default_nettype wire

// File: tb/tb_bitty_fetch_unit.sv
// Self-checking bench for bitty_fetch_unit: table programs, random programs
// against a transaction-level model, reset abort and watchdog sequences.
`default_nettype none

module tb_bitty_fetch_unit;

  localparam int ADDR_W    = 4;
  localparam int LAST_ADDR = 3;
  localparam int WDOG      = 64;

  logic              clk = 1'b0;
  logic              rst, start, done;
  logic [ADDR_W-1:0] mem_addr, pc;
  logic              mem_rd, run, busy, halted, wdog_err;
  logic [15:0]       mem_rdata = 16'h0000;
  logic [15:0]       instr;
  logic [15:0]       mem [0:15];

  int vectors     = 0;
  int miscompares = 0;

  // Observations collected by execute()
  int          obs_runs, obs_reads, obs_addr_bad, obs_gap_bad;
  logic [15:0] obs_instr_q[$];
  logic [ADDR_W-1:0] obs_pc_q[$];
  bit          obs_timeout;

  typedef struct {
    logic [3:0][15:0]  w;
    int                dly;
    bit                hold;
    int                exp_runs;
    logic [ADDR_W-1:0] exp_pc;
    logic [15:0]       exp_instr;
  } vec_t;

  vec_t tbl[6];

  bitty_fetch_unit #(.ADDR_W(ADDR_W), .LAST_ADDR(LAST_ADDR), .WDOG_CYCLES(WDOG)) dut (
    .clk(clk), .rst(rst), .start(start), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .mem_rdata(mem_rdata), .instr(instr), .run(run), .done(done), .pc(pc),
    .busy(busy), .halted(halted), .wdog_err(wdog_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_rd) mem_rdata <= mem[mem_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0][15:0] mk(input logic [15:0] a0, a1, a2, a3);
    mk = {a3, a2, a1, a0};
  endfunction

  // Reference: walk addresses until a halt word or the last address.
  function automatic void model(input logic [3:0][15:0] w, output int n,
                                output int hpc, output logic [15:0] hins);
    n = 0; hpc = LAST_ADDR; hins = w[LAST_ADDR];
    for (int a = 0; a <= LAST_ADDR; a++) begin
      if (w[a] == 16'hFFFF) begin
        hpc = a; hins = 16'hFFFF;
        return;
      end
      n++;
    end
  endfunction

  task automatic execute(input logic [3:0][15:0] w, input int dly_lo, input int dly_hi,
                         input bit hold);
    int next_done, last_run, last_d, d;
    for (int i = 0; i < 4; i++) mem[i] = w[i];
    obs_runs = 0; obs_reads = 0; obs_addr_bad = 0; obs_gap_bad = 0;
    obs_pc_q.delete(); obs_instr_q.delete(); obs_timeout = 1'b1;
    next_done = -1; last_run = -1; last_d = 0;
    done  = hold;
    start = 1'b1;
    for (int cyc = 0; cyc < 200; cyc++) begin
      @(negedge clk);
      if (cyc == 0) start = 1'b0;
      if (mem_rd) begin
        if (int'(mem_addr) != obs_reads) obs_addr_bad++;
        obs_reads++;
      end
      if (run) begin
        obs_runs++;
        obs_pc_q.push_back(pc);
        obs_instr_q.push_back(instr);
        if (last_run >= 0 && (cyc - last_run) != last_d + 3) obs_gap_bad++;
        d = hold ? 1 : int'($urandom_range(dly_hi, dly_lo));
        next_done = cyc + d;
        last_run = cyc;
        last_d = d;
      end
      if (!hold) done = (cyc == next_done);
      if (halted) begin
        obs_timeout = 1'b0;
        break;
      end
    end
    done = 1'b0;
  endtask

  task automatic compare(input string tag, input logic [3:0][15:0] w, input int n,
                         input int hpc, input logic [15:0] hins);
    check({tag, " timeout"}, {31'd0, obs_timeout}, 32'd0);
    check({tag, " run_count"}, obs_runs, n);
    for (int i = 0; i < n && i < obs_runs; i++) begin
      check({tag, " run_pc"}, obs_pc_q[i], i);
      check({tag, " run_instr"}, obs_instr_q[i], w[i]);
    end
    check({tag, " issue_gap_errs"}, obs_gap_bad, 0);
    check({tag, " mem_rd_count"}, obs_reads, hpc + 1);
    check({tag, " mem_addr_errs"}, obs_addr_bad, 0);
    check({tag, " halt_pc"}, pc, hpc);
    check({tag, " halt_instr"}, instr, hins);
    check({tag, " halt_busy"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " pc"}, pc, 0);
    check({tag, " mem_addr"}, mem_addr, 0);
    check({tag, " instr"}, instr, 0);
    check({tag, " flags"}, {mem_rd, run, busy, halted, wdog_err}, 0);
  endtask

  initial begin
    int n, hpc, bad, k;
    logic [15:0] hins;
    logic [3:0][15:0] w;

    tbl[0] = '{mk(16'h1234, 16'h5678, 16'h9ABC, 16'hFFFF), 2, 1'b0, 3, 4'd3, 16'hFFFF};
    tbl[1] = '{mk(16'h1111, 16'h2222, 16'h3333, 16'h4444), 1, 1'b0, 4, 4'd3, 16'h4444};
    tbl[2] = '{mk(16'hFFFF, 16'h2222, 16'h3333, 16'h4444), 2, 1'b0, 0, 4'd0, 16'hFFFF};
    tbl[3] = '{mk(16'hAAAA, 16'hFFFF, 16'h0000, 16'h0000), 3, 1'b0, 1, 4'd1, 16'hFFFF};
    tbl[4] = '{mk(16'h0000, 16'hFFFE, 16'h7FFF, 16'h8000), 4, 1'b0, 4, 4'd3, 16'h8000};
    tbl[5] = '{mk(16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0), 1, 1'b1, 4, 4'd3, 16'hDEF0};
    for (int i = 0; i < 16; i++) mem[i] = 16'h0000;

    rst = 1'b1; start = 1'b0; done = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (busy || mem_rd) bad++;
    end
    check("idle_without_start", bad, 0);

    foreach (tbl[i]) begin
      execute(tbl[i].w, tbl[i].dly, tbl[i].dly, tbl[i].hold);
      compare($sformatf("table%0d", i), tbl[i].w, tbl[i].exp_runs,
              int'(tbl[i].exp_pc), tbl[i].exp_instr);
    end

    for (int r = 0; r < 20; r++) begin
      for (int a = 0; a < 4; a++)
        w[a] = ($urandom_range(3, 0) == 0) ? 16'hFFFF : 16'($urandom);
      execute(w, 1, 5, 1'b0);
      model(w, n, hpc, hins);
      compare($sformatf("rand%0d", r), w, n, hpc, hins);
    end

    // Reset asserted between edges while waiting for done.
    for (int a = 0; a < 4; a++) mem[a] = 16'h1000 + 16'(a);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    k = 0;
    while (!run && k < 10) begin @(negedge clk); k++; end
    check("reach_issue", {31'd0, run}, 32'd1);
    repeat (2) @(negedge clk);
    @(posedge clk); #2 rst = 1'b1;
    #1 check_reset_vals("async_reset");
    @(negedge clk); rst = 1'b0;
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (busy || mem_rd || run || halted) bad++;
    end
    check("post_reset_idle", bad, 0);

    // Watchdog: done never asserted.
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    k = 0;
    while (!run && k < 10) begin @(negedge clk); k++; end
    check("wdog_reach_issue", {31'd0, run}, 32'd1);
`ifdef BITTY_FETCH_WATCHDOG_EN
    k = 0;
    while (!halted && k < 200) begin @(negedge clk); k++; end
    check("wdog_wait_cycles", k - 1, WDOG);
    check("wdog_err_set", {31'd0, wdog_err}, 32'd1);
    check("wdog_halted", {31'd0, halted}, 32'd1);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("wdog_err_cleared", {31'd0, wdog_err}, 32'd0);
    check("wdog_refetch", {mem_rd, 28'd0, 3'(mem_addr)}, {1'b1, 31'd0});
`else
    bad = 0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      if (!busy || halted || wdog_err || run || mem_rd) bad++;
    end
    check("no_wdog_stays_wait", bad, 0);
    check("no_wdog_err", {31'd0, wdog_err}, 32'd0);
`endif
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bitty_fetch_unit.md
# bitty_fetch_unit

Instruction fetch sequencer that sits directly upstream of the bitty core. It walks a program counter through a synchronous instruction memory and latches each 16-bit word. It presents the word on `instr` with a one-cycle `run` pulse, then waits for the core's `done` before advancing. Execution stops on a halt word, at the last address, or (when configured) on a watchdog timeout.

## Interface
- `ADDR_W`, 8: program counter and memory address width.
- `LAST_ADDR`, 2**ADDR_W-1: highest address fetched. After the instruction at this address completes, the unit halts.
- `WDOG_CYCLES`, 64: maximum number of WAIT cycles allowed before `done`; used only with the watchdog macro.

- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `start`  in  1  level; sampled in IDLE/HALT to begin execution from address 0.
- `mem_addr`  out  ADDR_W  instruction memory address (= pc).
- `mem_rd`  out  1  memory read strobe; data valid on `mem_rdata` the following cycle.
- `mem_rdata`  in  16  instruction memory read data.
- `instr`  out  16  latched instruction to core.
- `run`  out  1  one-cycle issue pulse to core.
- `done`  in  1  core completion; honoured only in WAIT.
- `pc`  out  ADDR_W  current program counter.
- `busy`  out  1  high in REQ/LATCH/ISSUE/WAIT.
- `halted`  out  1  high in HALT.
- `wdog_err`  out  1  sticky watchdog error flag.

## Operation
- States:
  - IDLE: `busy`=0. `start`=1 → pc←0, go to REQ.
  - REQ: `mem_rd`=1, `mem_addr`=pc → LATCH.
  - LATCH: `instr`←`mem_rdata`. If `mem_rdata`==16'hFFFF (halt word) → HALT with no `run` issued, and `instr` still updates. Otherwise → ISSUE.
  - ISSUE: `run`=1 for exactly this cycle → WAIT. `done` is ignored in this state.
  - WAIT: on `done`=1:
    - pc==LAST_ADDR → HALT, pc unchanged.
    - otherwise pc←pc+1 → REQ.
  - HALT: `halted`=1. `start`=1 → pc←0, clear `wdog_err`, go to REQ.
- `instr` holds stable from LATCH exit until the next LATCH.
- pc never wraps past LAST_ADDR. An increment beyond it is impossible by construction.
- `done` in IDLE, REQ, LATCH, ISSUE or HALT has no effect.
- `start` while `busy` is ignored.

## Timing
- Reset (asynchronous assert): state=IDLE; `pc`, `mem_addr`, `instr` = 0; `mem_rd`, `run`, `busy`, `halted`, `wdog_err` = 0.
- Reset mid-operation aborts immediately with the same values. No pending `run` survives.
- Reset deasserts synchronously to `clk` at the board level. The first transition out of IDLE is on the first edge with `start`=1.
- Per instruction, `run` rises 3 cycles after leaving IDLE/WAIT: REQ, LATCH, ISSUE.
- If `done` is seen in WAIT cycle n (n≥1 after ISSUE), the next `mem_rd` is in cycle n+1.
- Minimum issue interval is 4 cycles.
- `mem_rd` is a single-cycle pulse. Memory latency is exactly 1 cycle; no backpressure.

## Configuration
- `BITTY_FETCH_WATCHDOG_EN` defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle without `done`.
  - When it reaches WDOG_CYCLES: `wdog_err`←1 (sticky), go to HALT.
  - `done` in the same cycle as the count reaching WDOG_CYCLES wins: normal advance, no error.
- Not defined: no counter is built, `wdog_err` is tied 0, and WAIT lasts indefinitely.

## Test plan
- Memory {0:1234, 1:5678, 2:9ABC, 3:FFFF}, `done` 2 cycles after each `run`, start pulse:
  - Exactly three `run` pulses with `instr`=1234/5678/9ABC and pc=0/1/2.
  - `halted`=1 with pc=3 and no fourth `run`.
- LAST_ADDR=3, memory with no FFFF:
  - Four instructions issued.
  - Halt after `done` for addr 3; pc stays 3.
- `done` held high continuously from reset:
  - `done` during ISSUE is ignored.
  - Issue interval is exactly 4 cycles.
  - `mem_rd` pulses once per instruction.
- `rst` asserted mid-WAIT (asynchronous, between edges):
  - All outputs drop to reset values immediately.
  - After release, nothing happens until `start`.
- With macro, WDOG_CYCLES=64, `done` never asserted: `wdog_err`=1 and `halted`=1 after 64 WAIT cycles.
  - Then `start` clears `wdog_err` and refetches address 0.
- Without macro, same stimulus: unit stays in WAIT for 1000 cycles with `wdog_err`=0.
